// File: rtl/router_stat_pkg.sv
// Shared types for the router traffic monitor: stat categories and snapshot FSM states.
package router_stat_pkg;

  localparam int num_stat_cats_gp = 4;

  // Enum order is the packing order of a snapshot entry, LSB first.
  typedef enum logic [1:0] {IDLE, UTIL, STALL, ARB} stat_cat_e;

  typedef enum logic {S_IDLE, S_DRAIN} snap_state_e;

endpackage

// File: rtl/router_stat_counter.sv
// Saturating event counter. nxt_o is the post-event value before any clear so a
// capture taken in the same cycle as a clear still sees that cycle's event.
module router_stat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [width_p-1:0] nxt_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    nxt_o = cnt_q;
    if (en_i && inc_i && (cnt_q != '1)) nxt_o = cnt_q + 1'b1;
    cnt_d = clr_i ? '0 : nxt_o;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/router_stat_monitor.sv
// Per-output idle/util/stall/arb counters with atomic snapshot drained one direction
// per yumi. Define ROUTER_STAT_MONITOR_PERIODIC_EN to compile in the periodic trigger.
module router_stat_monitor import router_stat_pkg::*; #(
  parameter int dirs_p          = 5,
  parameter int ctr_width_p     = 32,
  parameter int period_p        = 256,
  parameter int seq_width_p     = 16,
  parameter int clear_on_snap_p = 0
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [dirs_p-1:0][dirs_p-1:0]          req_i,
  input  logic [dirs_p-1:0][dirs_p-1:0]          yumi_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  logic                                   snap_req_i,
  output logic                                   snap_v_o,
  output logic [$clog2(dirs_p)-1:0]              snap_dir_o,
  output logic [seq_width_p-1:0]                 snap_seq_o,
  output logic [num_stat_cats_gp*ctr_width_p-1:0] snap_data_o,
  input  logic                                   snap_yumi_i,
  output logic                                   drop_o
);

  localparam int dir_w_lp  = $clog2(dirs_p);
  localparam int data_w_lp = num_stat_cats_gp*ctr_width_p;

  logic [dirs_p-1:0][num_stat_cats_gp-1:0]                  ev;
  logic [dirs_p-1:0][num_stat_cats_gp-1:0][ctr_width_p-1:0] nxt;
  logic capture, ctr_clr, trig;

  assign ctr_clr = clear_i | (capture && (clear_on_snap_p != 0));

  for (genvar o = 0; o < dirs_p; o++) begin : g_dir
    logic [dirs_p-1:0] r, y;
    assign r = req_i[o];
    assign y = yumi_i[o];
    assign ev[o][IDLE]  = (r == '0);
    assign ev[o][UTIL]  = ((r & y) != '0);
    assign ev[o][STALL] = (r != '0) && (y == '0);
    assign ev[o][ARB]   = ((r & (r - 1'b1)) != '0) && (y != '0);
    for (genvar c = 0; c < num_stat_cats_gp; c++) begin : g_cat
      router_stat_counter #(.width_p(ctr_width_p)) u_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (enable_i),
        .inc_i   (ev[o][c]),
        .clr_i   (ctr_clr),
        .nxt_o   (nxt[o][c])
      );
    end
  end

`ifdef ROUTER_STAT_MONITOR_PERIODIC_EN
  localparam int tmr_w_lp = $clog2(period_p);
  logic [tmr_w_lp-1:0] tmr_q, tmr_d;
  logic                tmr_hit;

  assign tmr_hit = enable_i && (tmr_q == tmr_w_lp'(period_p-1));
  assign trig    = snap_req_i | tmr_hit;

  always_comb begin
    tmr_d = tmr_q;
    if (clear_i || tmr_hit) tmr_d = '0;
    else if (enable_i)      tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end
`else
  assign trig = snap_req_i;
`endif

  snap_state_e                      state_q, state_d;
  logic [dir_w_lp-1:0]              dir_q, dir_d;
  logic [seq_width_p-1:0]           seq_q, seq_d;
  logic [data_w_lp-1:0]             data_q, data_d;
  logic                             drop_q, drop_d;
  logic [dirs_p-1:0][data_w_lp-1:0] shadow_q;
  logic                             last;

  assign last = (dir_q == dir_w_lp'(dirs_p-1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    seq_d   = seq_q;
    data_d  = data_q;
    drop_d  = drop_q & ~clear_i;
    capture = 1'b0;
    case (state_q)
      S_IDLE:  capture = trig;
      S_DRAIN: begin
        if (snap_yumi_i && last) begin
          // A trigger on the final yumi starts the next snapshot back-to-back.
          capture = trig;
          if (!trig) begin
            state_d = S_IDLE;
            dir_d   = '0;
          end
        end else if (snap_yumi_i) begin
          dir_d  = dir_q + 1'b1;
          data_d = shadow_q[dir_d];
        end
        if (trig && !capture) drop_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      state_d = S_DRAIN;
      dir_d   = '0;
      seq_d   = seq_q + 1'b1;
      data_d  = nxt[0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      dir_q    <= '0;
      seq_q    <= '0;
      data_q   <= '0;
      drop_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      if (capture) shadow_q <= nxt;
    end
  end

  assign snap_v_o    = (state_q == S_DRAIN);
  assign snap_dir_o  = dir_q;
  assign snap_seq_o  = seq_q;
  assign snap_data_o = data_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_router_stat_monitor.sv
// Bench for router_stat_monitor: a cumulative 32-bit instance and a 4-bit delta-mode
// instance share stimulus and are checked against an event-count/queue model.
module tb_router_stat_monitor;

  localparam int D   = 5;
  localparam int PER = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic [D-1:0][D-1:0] req, yumi;
  logic enable, clear, snap_req, snap_yumi;
  logic v0, v1, drop0, drop1;
  logic [2:0] dir0, dir1;
  logic [15:0] seq0, seq1;
  logic [127:0] data0;
  logic [15:0] data1;

  always #5 clk = ~clk;

  router_stat_monitor #(.dirs_p(D), .ctr_width_p(32), .period_p(PER), .seq_width_p(16),
                        .clear_on_snap_p(0)) u_cum (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .yumi_i(yumi), .enable_i(enable),
    .clear_i(clear), .snap_req_i(snap_req), .snap_v_o(v0), .snap_dir_o(dir0),
    .snap_seq_o(seq0), .snap_data_o(data0), .snap_yumi_i(snap_yumi), .drop_o(drop0));

  router_stat_monitor #(.dirs_p(D), .ctr_width_p(4), .period_p(PER), .seq_width_p(16),
                        .clear_on_snap_p(1)) u_dlt (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .yumi_i(yumi), .enable_i(enable),
    .clear_i(clear), .snap_req_i(snap_req), .snap_v_o(v1), .snap_dir_o(dir1),
    .snap_seq_o(seq1), .snap_data_o(data1), .snap_yumi_i(snap_yumi), .drop_o(drop1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int dir; logic [127:0] d0; logic [15:0] d1; } ent_t;
  int unsigned m_c0[D][4];
  int unsigned m_c1[D][4];
  ent_t m_q[$];
  int m_seq, m_tmr;
  bit m_drop;

  function automatic int unsigned sat(input int unsigned x, input int unsigned mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic m_reset();
    foreach (m_c0[o, c]) begin m_c0[o][c] = 0; m_c1[o][c] = 0; end
    m_q.delete(); m_seq = 0; m_tmr = 0; m_drop = 0;
  endtask

  task automatic m_step(input logic [D-1:0][D-1:0] rq, yu, input logic en, clr, sr, sy);
    bit trig, busy, fin, cap, lost;
    bit [3:0] ev;
    ent_t e;
    if (en) for (int o = 0; o < D; o++) begin
      ev[0] = (rq[o] == 0);
      ev[1] = ((rq[o] & yu[o]) != 0);
      ev[2] = (rq[o] != 0) && (yu[o] == 0);
      ev[3] = ($countones(rq[o]) > 1) && (yu[o] != 0);
      for (int c = 0; c < 4; c++) if (ev[c]) begin
        if (m_c0[o][c] != 32'hFFFF_FFFF) m_c0[o][c]++;
        if (m_c1[o][c] < 15) m_c1[o][c]++;
      end
    end
    trig = sr;
`ifdef ROUTER_STAT_MONITOR_PERIODIC_EN
    if (en && m_tmr == PER-1) trig = 1;
`endif
    if (clr) m_tmr = 0; else if (en) m_tmr = (m_tmr + 1) % PER;
    busy = (m_q.size() != 0);
    fin  = busy && sy && (m_q.size() == 1);
    if (busy && sy) void'(m_q.pop_front());
    cap  = trig && (!busy || fin);
    lost = trig && busy && !fin;
    m_drop = (m_drop && !clr) || lost;
    if (cap) begin
      m_seq = (m_seq + 1) & 16'hFFFF;
      for (int d = 0; d < D; d++) begin
        e.dir = d;
        e.d0 = {32'(m_c0[d][3]), 32'(m_c0[d][2]), 32'(m_c0[d][1]), 32'(m_c0[d][0])};
        e.d1 = {4'(m_c1[d][3]), 4'(m_c1[d][2]), 4'(m_c1[d][1]), 4'(m_c1[d][0])};
        m_q.push_back(e);
      end
      foreach (m_c1[o, c]) m_c1[o][c] = 0;
    end
    if (clr) foreach (m_c0[o, c]) begin m_c0[o][c] = 0; m_c1[o][c] = 0; end
  endtask

  task automatic check_all();
    bit b = (m_q.size() != 0);
    chk("v0", 128'(v0), 128'(b));
    chk("v1", 128'(v1), 128'(b));
    chk("seq0", 128'(seq0), 128'(m_seq));
    chk("seq1", 128'(seq1), 128'(m_seq));
    chk("drop0", 128'(drop0), 128'(m_drop));
    chk("drop1", 128'(drop1), 128'(m_drop));
    if (b) begin
      chk("dir0", 128'(dir0), 128'(m_q[0].dir));
      chk("data0", data0, m_q[0].d0);
      chk("dir1", 128'(dir1), 128'(m_q[0].dir));
      chk("data1", 128'(data1), 128'(m_q[0].d1));
    end
  endtask

  task automatic cyc(input logic [D-1:0][D-1:0] rq, yu, input logic en, clr, sr, sy);
    req = rq; yumi = yu; enable = en; clear = clr; snap_req = sr; snap_yumi = sy;
    m_step(rq, yu, en, clr, sr, sy);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_q.size() != 0; i++) cyc('0, '0, 0, 0, 0, 1);
  endtask

  function automatic bit busy();
    return m_q.size() != 0;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int o; logic [D-1:0] ra, ya; int na; logic [D-1:0] rb, yb; int nb;
    int e_arb, e_stall, e_util, e_idle;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0][D-1:0] rq, yu;
    int base, ex_arb, ex_stall, ex_util, ex_idle;

    // dirs: P=0 W=1 E=2 N=3 S=4
    tbl[0] = '{2, 5'b00001, 5'b00001, 10, 5'b00000, 5'b00000, 0,  0, 0, 10, 0};
    tbl[1] = '{3, 5'b00110, 5'b00010, 6,  5'b00110, 5'b00000, 3,  6, 3, 6,  0};
    tbl[2] = '{0, 5'b00000, 5'b00000, 20, 5'b00000, 5'b00000, 0,  0, 0, 0,  20};
    tbl[3] = '{1, 5'b00001, 5'b00010, 4,  5'b00000, 5'b00000, 0,  0, 0, 0,  0};
    tbl[4] = '{4, 5'b11111, 5'b10000, 17, 5'b00000, 5'b00000, 0,  17, 0, 17, 0};

    reset_n = 0; req = '0; yumi = '0; enable = 0; clear = 0; snap_req = 0; snap_yumi = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", 128'(v0), 0);
    chk("rst_dir", 128'(dir0), 0);
    chk("rst_seq", 128'(seq0), 0);
    chk("rst_data", data0, 0);
    chk("rst_drop", 128'(drop0), 0);
    chk("rst_data1", 128'(data1), 0);
    reset_n = 1;
    cyc('0, '0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      cyc('0, '0, 0, 1, 0, 0);
      rq = '0; yu = '0; rq[tbl[k].o] = tbl[k].ra; yu[tbl[k].o] = tbl[k].ya;
      repeat (tbl[k].na) cyc(rq, yu, 1, 0, 0, 0);
      rq = '0; yu = '0; rq[tbl[k].o] = tbl[k].rb; yu[tbl[k].o] = tbl[k].yb;
      repeat (tbl[k].nb) cyc(rq, yu, 1, 0, 0, 0);
      cyc('0, '0, 0, 0, 1, 0);
      for (int d = 0; d < D; d++) begin
        if (d == tbl[k].o) begin
          ex_arb = tbl[k].e_arb; ex_stall = tbl[k].e_stall;
          ex_util = tbl[k].e_util; ex_idle = tbl[k].e_idle;
        end else begin
          ex_arb = 0; ex_stall = 0; ex_util = 0; ex_idle = tbl[k].na + tbl[k].nb;
        end
        chk("tbl_v", 128'(v0), 1);
        chk("tbl_dir", 128'(dir0), 128'(d));
        chk("tbl_cum", data0, {32'(ex_arb), 32'(ex_stall), 32'(ex_util), 32'(ex_idle)});
        chk("tbl_sat", 128'(data1), 128'({4'(sat(ex_arb, 15)), 4'(sat(ex_stall, 15)),
                                          4'(sat(ex_util, 15)), 4'(sat(ex_idle, 15))}));
        cyc('0, '0, 0, 0, 0, 1);
      end
      chk("tbl_done", 128'(v0), 0);
    end

    // drop on busy trigger; trigger coincident with final yumi is accepted
    cyc('0, '0, 0, 1, 0, 0);
    repeat (3) cyc('0, '0, 1, 0, 0, 0);
    cyc('0, '0, 0, 0, 1, 0);
    base = m_seq;
    repeat (3) cyc('0, '0, 1, 0, 0, 0);
    chk("drop_pre", 128'(drop0), 0);
    cyc('0, '0, 0, 0, 1, 0);
    chk("drop_set", 128'(drop0), 1);
    chk("drop_seq", 128'(seq0), 128'(base));
    repeat (D-1) cyc('0, '0, 0, 0, 0, 1);
    cyc('0, '0, 0, 0, 1, 1);
    chk("b2b_v", 128'(v0), 1);
    chk("b2b_dir", 128'(dir0), 0);
    chk("b2b_seq", 128'(seq0), 128'((base + 1) & 16'hFFFF));
    chk("b2b_drop", 128'(drop0), 1);
    drain();
    cyc('0, '0, 0, 1, 0, 0);
    chk("drop_clr", 128'(drop0), 0);

    // delta mode: constant traffic, snapshot every 8 cycles
    rq = '0; yu = '0; rq[2] = 5'b00001; yu[2] = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 7; j++) begin
        cyc(rq, yu, 1, 0, 0, busy());
        if (j == 1 && k > 0) begin
          chk("dlt_dir", 128'(dir1), 2);
          chk("dlt_util", 128'(data1[7:4]), 8);
          chk("cum_util", 128'(data0[63:32]), 128'(8*k));
        end
      end
      cyc(rq, yu, 1, 0, 1, 0);
    end
    drain();

    // reset during drain clears immediately
    cyc('0, '0, 0, 0, 1, 0);
    cyc('0, '0, 0, 0, 0, 1);
    cyc('0, '0, 0, 0, 0, 1);
    #2 reset_n = 0;
    #1;
    chk("rstm_v", 128'(v0), 0);
    chk("rstm_seq", 128'(seq0), 0);
    chk("rstm_dir", 128'(dir0), 0);
    chk("rstm_data", data0, 0);
    m_reset();
    @(posedge clk); #1 reset_n = 1;
    cyc('0, '0, 0, 0, 0, 0);

`ifdef ROUTER_STAT_MONITOR_PERIODIC_EN
    cyc('0, '0, 0, 1, 0, 0);
    base = m_seq;
    for (int i = 0; i < 2*PER; i++) begin
      cyc('0, '0, 1, 0, 0, busy() && (i != PER-1) && (i != 2*PER-1));
      if (i == PER-2) chk("per_early", 128'(v0), 0);
      if (i == PER-1) begin
        chk("per_v1", 128'(v0), 1);
        chk("per_seq1", 128'(seq0), 128'(base + 1));
      end
      if (i == 2*PER-1) begin
        chk("per_v2", 128'(v0), 1);
        chk("per_seq2", 128'(seq0), 128'(base + 2));
      end
    end
    drain();
`endif

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic en, cl, sr, sy;
      for (int o = 0; o < D; o++) begin
        rq[o] = D'($urandom) & D'($urandom);
        yu[o] = '0;
        if ($urandom_range(3) == 0) yu[o] = D'($urandom);
        else if (rq[o] != 0)
          for (int t = 0; t < 8; t++) begin
            int i = $urandom_range(D-1);
            if (rq[o][i] && yu[o] == 0 && $urandom_range(1)) yu[o][i] = 1'b1;
          end
      end
      en = ($urandom_range(9) != 0);
      cl = ($urandom_range(39) == 0);
      sr = ($urandom_range(11) == 0);
      sy = busy() && $urandom_range(1);
      cyc(rq, yu, en, cl, sr, sy);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/router_stat_monitor.md
# router_stat_monitor

Parametrised, synthesizable per-output traffic monitor that attaches beside a mesh/ruche router's crossbar arbitration. For every output direction it counts idle, utilized, stalled and arbitrated cycles in saturating counters. It captures all counters atomically on a periodic or on-demand trigger and serialises the snapshot one direction at a time over a valid/yumi port. It replaces file-based stat dumping with a hardware path that a host or trace unit can drain.

## Interface
Parameters:
- dirs_p, 5, router directions (P + 2*dims); 5 mesh, 7 ruche-X, 9 full ruche
- ctr_width_p, 32, width of each event counter
- period_p, 256, periodic trigger interval in enabled cycles (≥ dirs_p+1)
- seq_width_p, 16, snapshot sequence-number width
- clear_on_snap_p, 0, 1 = delta mode (counters zeroed after each capture); 0 = cumulative

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- req_i  in  dirs_p×dirs_p  req_i[o][i]: input i requests output o
- yumi_i  in  dirs_p×dirs_p  yumi_i[o][i]: output o grants input i
- enable_i  in  1  counting and period timer advance only when high
- clear_i  in  1  synchronous zeroing of all counters and the timer
- snap_req_i  in  1  on-demand snapshot trigger, single-cycle pulse
- snap_v_o  out  1  snapshot entry valid
- snap_dir_o  out  $clog2(dirs_p)  direction of the current entry
- snap_seq_o  out  seq_width_p  sequence number of the current snapshot
- snap_data_o  out  4*ctr_width_p  {arbitrated, stalled, utilized, idle}, MSB→LSB
- snap_yumi_i  in  1  consumer accepts the current entry; legal only while snap_v_o is high
- drop_o  out  1  sticky flag: a trigger was lost while draining; cleared by clear_i

## Operation
- Per output o, each cycle with enable_i=1:
  - idle += (req_i[o]==0)
  - utilized += ((req_i[o]&yumi_i[o])!=0)
  - stalled += (req_i[o]!=0 && yumi_i[o]==0)
  - arbitrated += (popcount(req_i[o])>1 && yumi_i[o]!=0)
- Counters saturate at all-ones and never wrap.
- Trigger = snap_req_i, or timer reaching period_p-1. The timer then wraps to 0.
- FSM IDLE/DRAIN:
  - IDLE + trigger → shadow ← next-state counter values for all dirs; snap_seq increments (wraps mod 2^seq_width_p); go to DRAIN with dir=0.
  - DRAIN: snap_v_o=1. Each snap_yumi_i advances dir. A yumi at dir=dirs_p-1 returns the FSM to IDLE.
  - Trigger during DRAIN is dropped and sets drop_o. Exception: a trigger in the same cycle as the final yumi is accepted and captured; DRAIN restarts at dir 0 the next cycle.
- clear_on_snap_p=1: counters go to 0 on the cycle after capture, and events of the capture cycle are included in that snapshot.
- clear_i and a trigger in the same cycle: the snapshot captures values that include that cycle's events; clear still zeroes the counters.
- clear_i does not abort a drain in progress.
- enable_i=0: counters and timer hold; snap_req_i is still honoured.

## Timing
- Reset values: snap_v_o=0, snap_dir_o=0, snap_seq_o=0, snap_data_o=0, drop_o=0; FSM in IDLE; all counters and timer at 0.
- Trigger at cycle t → snap_v_o=1 at t+1. Minimum drain time is dirs_p cycles with yumi held high.
- snap_data_o and snap_dir_o are registered and stable while snap_v_o=1 and snap_yumi_i=0.
- Reset asserted mid-drain clears everything immediately. The in-flight snapshot is lost and the sequence restarts at 0.

## Configuration
- ROUTER_STAT_MONITOR_PERIODIC_EN defined: the period timer and its trigger are compiled in.
- Macro undefined: no timer logic; only snap_req_i triggers; period_p is ignored.

## Structure
- Package router_stat_pkg holds:
  - enum stat_cat_e {IDLE, UTIL, STALL, ARB}
  - localparam num_stat_cats_gp=4
  - FSM state enum
- Sub-module router_stat_counter: saturating counter with enable, increment bit and sync clear, parameterised by width. It is instantiated 4×dirs_p times.

## Test plan
- dirs_p=5, 10 cycles, req_i[E]=one input, yumi=that input each cycle, then snap_req_i → dir E entry {0,0,10,0}; all other dirs report idle=10.
- Two inputs request output N for 6 cycles with one granted each cycle, plus 3 cycles of req with no yumi → N = {arb=6, stall=3, util=6, idle=rest}.
- ctr_width_p=4, 20 idle cycles → idle=15 (saturated, no wrap).
- Periodic macro on, period_p=16, enable high → triggers at cycles 16, 32; snap_seq_o 1 then 2.
- clear_on_snap_p=1, constant traffic → successive snapshots report equal deltas of period_p.
- snap_yumi_i held low, second snap_req_i → drop_o=1; a trigger coincident with the final yumi → new snapshot, drop_o unchanged.
